// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and classification helper, used by the ALU and
// the result stage.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDC = 3'd1,
        OP_SUB  = 3'd2,
        OP_SUBC = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_MASK = 3'd7
    } alu_op_e;

    // Arithmetic ops are the only ones that produce a meaningful carry/borrow.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ADDC) || (op == OP_SUB) || (op == OP_SUBC);
    endfunction

endpackage

// File: rtl/result_skid.sv
// Two-entry skid buffer with registered ready; outputs always show the oldest
// entry. Only compiled when EXEC_RESULT_SKID_EN is defined.
`ifdef EXEC_RESULT_SKID_EN
module result_skid #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] ent0_q, ent1_q;
    logic [1:0]   count_q, count_d;
    logic         ready_q;
    logic         push, pop;
    logic [1:0]   widx;

    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = ent0_q;

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        widx    = count_q - {1'b0, pop};
    end

    // A pop shifts entry 1 down; a same-cycle push then lands behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            if (pop)
                ent0_q <= ent1_q;
            if (push) begin
                case (widx)
                    2'd0:    ent0_q <= in_data;
                    2'd1:    ent1_q <= in_data;
                    default: ;
                endcase
            end
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
        end
    end

endmodule
`endif

// File: rtl/exec_result_stage.sv
// ALU result register stage with valid/ready handshake and carry/zero flags.
// Define EXEC_RESULT_SKID_EN for a 2-entry skid buffer instead of one entry.
module exec_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DEST_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        alu_out,
    input  logic              alu_zero,
    input  logic              alu_cout,
    input  logic [2:0]        opcode,
    input  logic [DEST_W-1:0] dest,
    input  logic              clr_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic              carry_flag,
    output logic              zero_flag
);

    logic in_fire;
    logic carry_q, carry_d;
    logic zero_q, zero_d;

    assign in_fire    = in_valid & in_ready;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

    // Flags track acceptance, not writeback, so backpressure never delays cin.
    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (in_fire) begin
            zero_d = alu_zero;
            if (is_arith(opcode))
                carry_d = alu_cout;
        end
        if (clr_carry)
            carry_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

`ifdef EXEC_RESULT_SKID_EN
    logic                skid_ready;
    logic [DEST_W+7:0]   skid_data;

    result_skid #(
        .W (DEST_W + 8)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (skid_ready),
        .in_data   ({alu_out, dest}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_data)
    );

    assign {out_data, out_dest} = skid_data;
    assign in_ready = skid_ready & ~rst;
`else
    logic              valid_q, valid_d;
    logic [7:0]        data_q, data_d;
    logic [DEST_W-1:0] dest_q, dest_d;

    assign in_ready  = ~rst & (~valid_q | out_ready);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_dest  = dest_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        dest_d  = dest_q;
        if (in_fire) begin
            valid_d = 1'b1;
            data_d  = alu_out;
            dest_d  = dest;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
        end
    end
`endif

endmodule

// File: tb/tb_exec_result_stage.sv
// Scoreboard bench for exec_result_stage: a driver records accepted results in
// a queue, a negedge monitor checks outputs, handshake and flags against it.
module tb_exec_result_stage;

`ifdef EXEC_RESULT_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] alu_out = '0;
    logic       alu_zero = 1'b0;
    logic       alu_cout = 1'b0;
    logic [2:0] opcode = '0;
    logic [2:0] dest = '0;
    logic       clr_carry = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] out_dest;
    logic       carry_flag;
    logic       zero_flag;

    int checks = 0;
    int errors = 0;

    logic [10:0] sb[$];
    logic        m_carry = 1'b0;
    logic        m_zero  = 1'b0;
    logic        post_rst = 1'b0;

    always #5 clk = ~clk;

    exec_result_stage #(.DEST_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_cout   (alu_cout),
        .opcode     (opcode),
        .dest       (dest),
        .clr_carry  (clr_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_dest   (out_dest),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are compared mid-cycle against the scoreboard state.
    always @(negedge clk) begin
        logic [10:0] e;
        logic        exp_rdy;
        if (rst) begin
            chk("in_ready_in_rst", 32'(in_ready), 32'd0);
            post_rst = 1'b1;
        end else begin
            exp_rdy = (DEPTH == 2) ? (sb.size() < 2) : (sb.size() == 0 || out_ready);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("carry_flag", 32'(carry_flag), 32'(m_carry));
            chk("zero_flag", 32'(zero_flag), 32'(m_zero));
            if (post_rst) begin
                chk("out_data_after_rst", 32'(out_data), 32'd0);
                chk("out_dest_after_rst", 32'(out_dest), 32'd0);
                post_rst = 1'b0;
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e[10:3]));
                chk("out_dest", 32'(out_dest), 32'(e[2:0]));
            end
        end
    end

    // One clock cycle: drive just after the edge, record acceptance just before the next.
    task automatic step(input logic v, input logic [7:0] d, input logic [2:0] op,
                        input logic co, input logic z, input logic clr,
                        input logic ordy, input logic r);
        @(posedge clk);
        #1;
        rst       = r;
        in_valid  = v;
        alu_out   = d;
        opcode    = op;
        alu_cout  = co;
        alu_zero  = z;
        clr_carry = clr;
        out_ready = ordy;
        dest      = 3'($urandom_range(0, 7));
        #7;
        if (rst) begin
            sb.delete();
            m_carry = 1'b0;
            m_zero  = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back({alu_out, dest});
                m_zero = alu_zero;
                if (opcode < 3'd4)
                    m_carry = alu_cout;
            end
            if (clr_carry)
                m_carry = 1'b0;
        end
    endtask

    initial begin
        step(0, 8'h00, 3'd0, 0, 0, 0, 1, 1);
        step(0, 8'h00, 3'd0, 0, 0, 0, 1, 1);
        step(0, 8'h00, 3'd0, 0, 0, 0, 1, 0);
        // ADD result 0 with carry and zero
        step(1, 8'h00, 3'd0, 1, 1, 0, 1, 0);
        step(0, 8'h00, 3'd0, 0, 0, 0, 1, 0);
        // logic op keeps carry
        step(1, 8'h5A, 3'd4, 0, 0, 0, 1, 0);
        step(0, 8'h00, 3'd0, 0, 0, 0, 1, 0);
        // backpressure
        step(1, 8'h11, 3'd5, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 8'h22, 3'd6, 0, 0, 0, 0, 0);
        step(1, 8'h22, 3'd6, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 3'd0, 0, 0, 0, 1, 0);
        // streaming
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 3'(i % 8), 1'(i % 2), 0, 0, 1, 0);
        step(0, 8'h00, 3'd0, 0, 0, 0, 1, 0);
        // clear beats arithmetic carry
        step(1, 8'h80, 3'd2, 1, 0, 1, 1, 0);
        step(0, 8'h00, 3'd0, 0, 0, 0, 1, 0);
        // reset while stalled and full
        step(1, 8'hA1, 3'd0, 1, 0, 0, 0, 0);
        step(1, 8'hA2, 3'd1, 1, 1, 0, 0, 0);
        step(1, 8'hA3, 3'd2, 1, 1, 0, 0, 0);
        step(0, 8'h00, 3'd0, 0, 0, 0, 0, 1);
        step(0, 8'h00, 3'd0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom),
                 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 149) == 0));
        end
        for (int i = 0; i < 6; i++) step(0, 8'h00, 3'd0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
